rx_pie_decoder: RTL and testbench
=================================

# rx_pie_decoder

Parametrised PIE receive decoder for the tag front end: converts the demodulated reader envelope into a serial bit stream with a per-bit valid strobe. It detects the frame preamble (delimiter, data-0, RTcal, optional TRcal) and measures RTcal/TRcal in clock cycles. It also adds input synchronisation, glitch filtering, end-of-frame detection, error reporting and a received-bit counter. Sits between the analog demodulator and the command parser; `trcal` feeds backscatter clock calibration.

## Interface
- CW, 10, width of the symbol-length counter and of `rtcal`/`trcal`
- GLITCH, 2, consecutive cycles `demodin` must hold a new level before it is accepted (1..15)
- DELIM_MIN, 4, minimum low-time, in cycles, for a valid delimiter
- BCW, 8, width of `bit_count`

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- demodin  in  1  asynchronous demodulator output; low = reader pulse
- bit_out  out  1  decoded data bit; valid when `bit_valid`=1
- bit_valid  out  1  one-cycle strobe per decoded data bit
- bit_count  out  BCW  data bits decoded in current frame; saturates
- rtcal  out  CW  measured RTcal length in cycles
- trcal  out  CW  measured TRcal length in cycles
- trcal_valid  out  1  level; set when TRcal was seen in the current frame
- frame_active  out  1  high from end of delimiter to frame end/error
- frame_done  out  1  one-cycle pulse at normal end of frame
- rx_error  out  1  one-cycle pulse on protocol error or counter saturation
- rng_bit  out  1  LSB of symbol counter captured at each filtered rising edge (entropy source)

## Operation
- Input path: 2-flop synchroniser, then deglitch filter; filtered level `df` changes only after GLITCH consecutive cycles at the new level. `df` resets to 1.
- Counter: CW bits; cleared at each `df` rising edge, then +1 per cycle; saturates at all-ones. Value captured at a rising edge = symbol period in cycles. A separate low-time counter measures the delimiter.
- States: IDLE, DELIM, DATA0, RTCAL, FIRST, BITS.
  - IDLE: `df` falling -> DELIM.
  - DELIM: on `df` rising, low-time >= DELIM_MIN -> DATA0, `frame_active`=1; else -> IDLE with no error.
  - DATA0: next rising edge -> RTCAL; capture period as d0.
  - RTCAL: next rising edge: capture `rtcal`; if rtcal <= d0 -> `rx_error`, IDLE; else -> FIRST.
  - FIRST: at rising edge, period > rtcal -> `trcal` <= period, `trcal_valid`=1, -> BITS (no bit emitted). Otherwise decode as a data bit, -> BITS.
  - BITS: at each rising edge, `bit_out` = (period > rtcal>>1), `bit_valid` pulse, `bit_count`+1 (saturate at all-ones).
  - End of frame: in FIRST/BITS, counter exceeds rtcal while `df`=1 -> `frame_done` pulse, `frame_active`=0, -> IDLE.
  - In FIRST/BITS, counter exceeds rtcal while `df`=0 -> `rx_error`, IDLE. In any other non-IDLE state, counter saturation -> `rx_error`, IDLE.
- On entering DATA0, clear `bit_count` and `trcal_valid`. Hold `rtcal`/`trcal` values until overwritten.

## Timing
- Reset (reset=0 at a clk edge): all outputs 0, `df`=1, state IDLE, counters 0.
- Latency: `demodin` rising edge -> `bit_valid` = 2 (sync) + GLITCH + 1 cycles.
- The `bit_valid`, `frame_done` and `rx_error` pulses are mutually exclusive and last exactly one cycle. No backpressure is applied.
- A period exactly equal to rtcal>>1 decodes as 0. A period exactly equal to rtcal in FIRST is a data bit, not TRcal.
- Reset asserted mid-frame aborts the frame without `frame_done` or `rx_error`.
- A `demodin` pulse shorter than GLITCH cycles is invisible downstream.

## Structure
- Package `rx_pie_pkg`: state enum, default parameter constants, helper for the pivot (rtcal>>1).
- Sub-module `rx_deglitch`, parameter GLITCH: synchroniser plus stable-level filter, output `df` and a one-cycle `df_rise` pulse.

## Test plan
- Preamble: delim 10, data0 period 20, RTcal 50, TRcal 120, bits of period 20/40 -> `rtcal`=50, `trcal`=120, `trcal_valid`=1, bits 0,1, `bit_count`=2, then high for >50 cycles -> `frame_done`.
- No TRcal (RTcal 50, first period 40) -> first `bit_out`=1, `trcal_valid`=0.
- Glitch: 1-cycle low spike with GLITCH=2 mid-bit -> no extra `bit_valid`, bit sequence unchanged.
- Boundaries: period 25 with RTcal 50 -> bit 0; period 26 -> bit 1; delimiter of DELIM_MIN-1 -> stays IDLE, no error.
- Error: RTcal period 18 after data0 20 -> `rx_error` pulse, IDLE. `demodin` held low for more than rtcal cycles in BITS -> `rx_error`.
- Reset (reset=0) mid-BITS -> all outputs 0 next cycle. A new preamble then decodes normally.

Source files
------------

// File: rtl/rx_pie_pkg.sv
// Shared types and defaults for the PIE receive decoder.
package rx_pie_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_DELIM, S_DATA0, S_RTCAL, S_FIRST, S_BITS
  } state_t;

  localparam int CW_DEF        = 10;
  localparam int GLITCH_DEF    = 2;
  localparam int DELIM_MIN_DEF = 4;
  localparam int BCW_DEF       = 8;

  // Data-0 / data-1 decision threshold
  function automatic logic [31:0] pivot(input logic [31:0] rt);
    return rt >> 1;
  endfunction

endpackage

// File: rtl/rx_deglitch.sv
// Two-flop synchroniser followed by a stable-level filter on the demod envelope.
module rx_deglitch #(
  parameter int GLITCH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic demodin,
  output logic df,
  output logic df_rise
);

  logic       s1, s2;
  logic [3:0] run;

  // Sync flops idle high so reset release never looks like a reader pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      df      <= 1'b1;
      df_rise <= 1'b0;
      run     <= '0;
    end else begin
      s1      <= demodin;
      s2      <= s1;
      df_rise <= 1'b0;
      if (s2 == df) begin
        run <= '0;
      end else if (run == 4'(GLITCH - 1)) begin
        df      <= s2;
        df_rise <= s2;
        run     <= '0;
      end else begin
        run <= run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_pie_decoder.sv
// PIE receive decoder: preamble detection, RTcal/TRcal measurement and bit slicing
// on the filtered reader envelope.
module rx_pie_decoder
  import rx_pie_pkg::*;
#(
  parameter int CW        = CW_DEF,
  parameter int GLITCH    = GLITCH_DEF,
  parameter int DELIM_MIN = DELIM_MIN_DEF,
  parameter int BCW       = BCW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           demodin,
  output logic           bit_out,
  output logic           bit_valid,
  output logic [BCW-1:0] bit_count,
  output logic [CW-1:0]  rtcal,
  output logic [CW-1:0]  trcal,
  output logic           trcal_valid,
  output logic           frame_active,
  output logic           frame_done,
  output logic           rx_error,
  output logic           rng_bit
);

  localparam logic [CW-1:0]  CMAX = '1;
  localparam logic [BCW-1:0] BMAX = '1;

  logic          df, df_rise, df_q;
  logic [CW-1:0] cnt, lcnt, d0;
  logic [CW+1:0] limit;
  logic          timeout;
  state_t        state;

  rx_deglitch #(.GLITCH(GLITCH)) u_dg (
    .clk     (clk),
    .reset   (reset),
    .demodin (demodin),
    .df      (df),
    .df_rise (df_rise)
  );

  // FIRST may be carrying TRcal (up to 3x RTcal), so its end-of-symbol limit is stretched
  always_comb begin
    limit   = (state == S_FIRST) ? ({1'b0, rtcal, 1'b0} + {2'b0, rtcal}) : {2'b0, rtcal};
    timeout = ({2'b0, cnt} > limit) || (cnt == CMAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lcnt         <= '0;
      d0           <= '0;
      df_q         <= 1'b1;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      bit_count    <= '0;
      rtcal        <= '0;
      trcal        <= '0;
      trcal_valid  <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      rx_error     <= 1'b0;
      rng_bit      <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      rx_error   <= 1'b0;
      df_q       <= df;
      // The rise cycle is the first cycle of the new symbol, so cnt at the next rise = period
      cnt  <= df_rise ? CW'(1) : ((cnt == CMAX) ? cnt : cnt + 1'b1);
      lcnt <= df ? '0 : ((lcnt == CMAX) ? lcnt : lcnt + 1'b1);
      if (df_rise) rng_bit <= cnt[0];

      case (state)
        S_IDLE: if (df_q && !df) state <= S_DELIM;
        S_DELIM: begin
          if (df_rise) begin
            if (lcnt >= CW'(DELIM_MIN)) begin
              state        <= S_DATA0;
              frame_active <= 1'b1;
              bit_count    <= '0;
              trcal_valid  <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else if (lcnt == CMAX) begin
            rx_error <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_DATA0: begin
          if (df_rise) begin
            d0    <= cnt;
            state <= S_RTCAL;
          end else if (cnt == CMAX) begin
            rx_error     <= 1'b1;
            frame_active <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_RTCAL: begin
          if (df_rise) begin
            rtcal <= cnt;
            if (cnt <= d0) begin
              rx_error     <= 1'b1;
              frame_active <= 1'b0;
              state        <= S_IDLE;
            end else begin
              state <= S_FIRST;
            end
          end else if (cnt == CMAX) begin
            rx_error     <= 1'b1;
            frame_active <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_FIRST, S_BITS: begin
          if (df_rise) begin
            if (state == S_FIRST && cnt > rtcal) begin
              trcal       <= cnt;
              trcal_valid <= 1'b1;
            end else begin
              bit_out   <= 32'(cnt) > pivot(32'(rtcal));
              bit_valid <= 1'b1;
              if (bit_count != BMAX) bit_count <= bit_count + 1'b1;
            end
            state <= S_BITS;
          end else if (timeout) begin
            frame_done   <= df;
            rx_error     <= !df;
            frame_active <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_pie_decoder.sv
// Directed bench for rx_pie_decoder: table of bit periods plus hand sequences.
module tb_rx_pie_decoder;

  localparam int CW = 10, GLITCH = 2, DELIM_MIN = 4, BCW = 8;
  localparam int LO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           demodin;
  logic           bit_out, bit_valid, trcal_valid, frame_active, frame_done, rx_error, rng_bit;
  logic [BCW-1:0] bit_count;
  logic [CW-1:0]  rtcal, trcal;

  rx_pie_decoder #(.CW(CW), .GLITCH(GLITCH), .DELIM_MIN(DELIM_MIN), .BCW(BCW)) dut (
    .clk          (clk),
    .reset        (reset),
    .demodin      (demodin),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .bit_count    (bit_count),
    .rtcal        (rtcal),
    .trcal        (trcal),
    .trcal_valid  (trcal_valid),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .rx_error     (rx_error),
    .rng_bit      (rng_bit)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0, failures = 0;
  logic bq[$];
  int   fd_n = 0, err_n = 0, excl_bad = 0, bv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bit_valid) begin
        bq.push_back(bit_out);
        bv_cyc = cyc;
      end
      if (frame_done) fd_n = fd_n + 1;
      if (rx_error) err_n = err_n + 1;
      if (int'(bit_valid) + int'(frame_done) + int'(rx_error) > 1) excl_bad = excl_bad + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    demodin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic sym(input int p);
    hold(1'b1, p - LO);
    hold(1'b0, LO);
  endtask

  task automatic preamble(input int rt, input int tr);
    hold(1'b0, 10);
    sym(20);
    sym(rt);
    if (tr > 0) sym(tr);
  endtask

  task automatic chk_bits(input string name, input int base, input logic [7:0] exp, input int n);
    chk({name, "_n"}, bq.size() - base, n);
    for (int i = 0; i < n && base + i < bq.size(); i++)
      chk({name, "_bit"}, int'(bq[base + i]), int'(exp[n - 1 - i]));
  endtask

  typedef struct { int per; logic exp; } vec_t;
  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b0, f0, e0, t_rise;
    vecs[0] = '{20, 1'b0}; vecs[1] = '{40, 1'b1}; vecs[2] = '{25, 1'b0};
    vecs[3] = '{26, 1'b1}; vecs[4] = '{12, 1'b0}; vecs[5] = '{50, 1'b1};
    vecs[6] = '{30, 1'b1}; vecs[7] = '{24, 1'b0};

    reset = 1'b0; demodin = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", int'({bit_out, bit_valid, bit_count, rtcal, trcal, trcal_valid,
                             frame_active, frame_done, rx_error, rng_bit}), 0);
    reset = 1'b1;
    hold(1'b1, 20);

    // Full preamble with TRcal, then the bit table
    b0 = bq.size(); f0 = fd_n; e0 = err_n;
    preamble(50, 120);
    chk("t1_active", int'(frame_active), 1);
    foreach (vecs[i]) sym(vecs[i].per);
    t_rise = cyc;
    hold(1'b1, 60);
    chk("t1_rtcal", int'(rtcal), 50);
    chk("t1_trcal", int'(trcal), 120);
    chk("t1_trcal_valid", int'(trcal_valid), 1);
    chk("t1_n", bq.size() - b0, 8);
    foreach (vecs[i])
      if (b0 + i < bq.size()) chk("t1_bit", int'(bq[b0 + i]), int'(vecs[i].exp));
    chk("t1_bit_count", int'(bit_count), 8);
    chk("t1_latency", bv_cyc - t_rise, 2 + GLITCH + 1);
    chk("t1_done", fd_n - f0, 1);
    chk("t1_err", err_n - e0, 0);
    chk("t1_inactive", int'(frame_active), 0);

    // No TRcal: first symbol is a data bit
    b0 = bq.size(); f0 = fd_n;
    preamble(50, 0);
    sym(40); sym(20);
    hold(1'b1, 60);
    chk_bits("t2", b0, 8'b10, 2);
    chk("t2_trcal_valid", int'(trcal_valid), 0);
    chk("t2_trcal_held", int'(trcal), 120);
    chk("t2_bit_count", int'(bit_count), 2);
    chk("t2_done", fd_n - f0, 1);

    // One-cycle low spike mid-bit must be invisible
    b0 = bq.size(); e0 = err_n;
    preamble(50, 0);
    sym(20);
    hold(1'b1, 10); hold(1'b0, 1); hold(1'b1, 21); hold(1'b0, LO);
    sym(20);
    hold(1'b1, 60);
    chk_bits("t3", b0, 8'b010, 3);
    chk("t3_bit_count", int'(bit_count), 3);
    chk("t3_err", err_n - e0, 0);

    // Delimiter one cycle short: stay idle, no error
    b0 = bq.size(); e0 = err_n; f0 = fd_n;
    hold(1'b0, DELIM_MIN - 1);
    hold(1'b1, 40);
    chk("t4_active", int'(frame_active), 0);
    chk("t4_err", err_n - e0, 0);
    chk("t4_bits", bq.size() - b0, 0);
    chk("t4_done", fd_n - f0, 0);

    // RTcal not longer than data-0
    e0 = err_n; f0 = fd_n;
    hold(1'b0, 10); sym(20); sym(18);
    hold(1'b1, 30);
    chk("t5_err", err_n - e0, 1);
    chk("t5_rtcal", int'(rtcal), 18);
    chk("t5_active", int'(frame_active), 0);
    chk("t5_done", fd_n - f0, 0);

    // Envelope stuck low during BITS
    b0 = bq.size(); e0 = err_n; f0 = fd_n;
    preamble(50, 0);
    sym(20);
    hold(1'b1, 12); hold(1'b0, 70);
    hold(1'b1, 20);
    chk("t6_err", err_n - e0, 1);
    chk("t6_bits", bq.size() - b0, 1);
    chk("t6_done", fd_n - f0, 0);
    chk("t6_active", int'(frame_active), 0);

    // Reset mid-BITS, then a fresh frame with new calibration
    e0 = err_n; f0 = fd_n;
    preamble(50, 120);
    sym(20); sym(40);
    hold(1'b1, 5);
    reset = 1'b0;
    @(negedge clk);
    chk("t7_reset_outs", int'({bit_out, bit_valid, bit_count, rtcal, trcal, trcal_valid,
                               frame_active, frame_done, rx_error, rng_bit}), 0);
    hold(1'b1, 2);
    reset = 1'b1;
    hold(1'b1, 20);
    chk("t7_no_done", fd_n - f0, 0);
    chk("t7_no_err", err_n - e0, 0);
    b0 = bq.size();
    preamble(60, 150);
    sym(30); sym(31);
    hold(1'b1, 70);
    chk("t7_rtcal", int'(rtcal), 60);
    chk("t7_trcal", int'(trcal), 150);
    chk_bits("t7", b0, 8'b01, 2);
    chk("t7_done", fd_n - f0, 1);

    chk("pulse_exclusive", excl_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
